// File: rtl/stage_mem_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access types, write-back
// select codes, exception codes, FSM state codes and the bus timeout.
package stage_mem_lsu_pkg;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam int unsigned TIMEOUT_CYCLES = 16;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Unknown load codes and store code 11 both fall back to a full word.
  function automatic logic [1:0] access_size(input logic       is_store,
                                             input logic [2:0] ld_type,
                                             input logic [1:0] st_type);
    logic [1:0] sz;
    sz = SZ_WORD;
    if (is_store) begin
      case (st_type)
        ST_SB:   sz = SZ_BYTE;
        ST_SH:   sz = SZ_HALF;
        ST_SW:   sz = SZ_WORD;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (ld_type)
        LD_LB, LD_LBU: sz = SZ_BYTE;
        LD_LH, LD_LHU: sz = SZ_HALF;
        default:       sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or
// zero-extends it to 32 bits according to the load type.
module lsu_load_align
  import stage_mem_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (load_type)
      LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      LD_LH:   data = {{16{half_sel[15]}}, half_sel};
      LD_LBU:  data = {24'h000000, byte_sel};
      LD_LHU:  data = {16'h0000, half_sel};
      LD_LW:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/stage_mem_lsu.sv
// MEM pipeline stage: issues data-memory accesses, waits for ack with a bus
// timeout, flags misalignment, and registers the MEM/WB payload.
//
//   state  | meaning
//   IDLE   | no access outstanding; a new aligned access is issued here
//   WAIT   | access issued without ack; request held until ack or timeout
module stage_mem_lsu
  import stage_mem_lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_alu,
  input  logic [31:0] i_rs2,
  input  logic        i_memrw,
  input  logic [2:0]  i_load_type,
  input  logic [1:0]  i_store_type,
  input  logic [1:0]  i_wb_sel,
  input  logic        i_regwen,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic [31:0] o_alu,
  output logic [31:0] o_ld_data,
  output logic [1:0]  o_wb_sel,
  output logic        o_regwen,
  output logic        o_valid,
  output logic        o_stall,
  output logic [1:0]  o_exc
);

  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT_CYCLES - 1);

  logic [0:0]  state_q;
  logic [3:0]  wait_cnt_q;
  logic        is_load;
  logic        is_store;
  logic        mem_op;
  logic        misaligned;
  logic        access;
  logic        complete;
  logic        timeout;
  logic [1:0]  size;
  logic [31:0] ld_aligned;

  always_comb begin
    is_load    = (i_wb_sel == WB_MEM) && !i_memrw;
    is_store   = i_memrw;
    mem_op     = is_load || is_store;
    size       = access_size(is_store, i_load_type, i_store_type);
    misaligned = mem_op && (((size == SZ_HALF) && i_alu[0]) ||
                            ((size == SZ_WORD) && (i_alu[1:0] != 2'b00)));
    // Reset gates the request so a pending access is dropped immediately.
    access     = mem_op && !misaligned && !i_rst;
    complete   = access && i_dmem_ack;
    timeout    = access && !i_dmem_ack && (state_q == S_WAIT) &&
                 (wait_cnt_q == WAIT_LAST);
  end

  assign o_stall      = access && !complete && !timeout;
  assign o_dmem_req   = access;
  assign o_dmem_we    = access && is_store;
  assign o_dmem_addr  = {i_alu[31:2], 2'b00};

  always_comb begin
    case (size)
      SZ_BYTE: begin
        o_dmem_be    = 4'b0001 << i_alu[1:0];
        o_dmem_wdata = {4{i_rs2[7:0]}};
      end
      SZ_HALF: begin
        o_dmem_be    = 4'b0011 << i_alu[1:0];
        o_dmem_wdata = {2{i_rs2[15:0]}};
      end
      default: begin
        o_dmem_be    = 4'b1111;
        o_dmem_wdata = i_rs2;
      end
    endcase
  end

  lsu_load_align u_load_align (
    .rdata     (i_dmem_rdata),
    .addr_lo   (i_alu[1:0]),
    .load_type (i_load_type),
    .data      (ld_aligned)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 4'd0;
      o_pc       <= 32'h0;
      o_inst     <= 32'h0;
      o_alu      <= 32'h0;
      o_ld_data  <= 32'h0;
      o_wb_sel   <= 2'b00;
      o_regwen   <= 1'b0;
      o_valid    <= 1'b0;
      o_exc      <= EXC_NONE;
    end else if (o_stall) begin
      state_q    <= S_WAIT;
      wait_cnt_q <= (state_q == S_IDLE) ? 4'd0 : wait_cnt_q + 4'd1;
      o_inst     <= 32'h0;
      o_wb_sel   <= 2'b00;
      o_regwen   <= 1'b0;
      o_valid    <= 1'b0;
      o_exc      <= EXC_NONE;
    end else begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 4'd0;
      o_pc       <= i_pc;
      o_inst     <= i_inst;
      o_alu      <= i_alu;
      o_wb_sel   <= i_wb_sel;
      o_regwen   <= i_regwen && !misaligned && !timeout;
      o_valid    <= 1'b1;
      o_exc      <= misaligned ? EXC_MISALIGN : (timeout ? EXC_TIMEOUT : EXC_NONE);
      if (complete && is_load) begin
        o_ld_data <= ld_aligned;
      end
    end
  end

endmodule

// File: tb/tb_stage_mem_lsu.sv
// Directed bench for stage_mem_lsu with a cycle-level behavioural model and
// a few literal expectations for the headline scenarios.
module tb_stage_mem_lsu;
  import stage_mem_lsu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_pc = '0, i_inst = '0, i_alu = '0, i_rs2 = '0;
  logic        i_memrw = 1'b0;
  logic [2:0]  i_load_type = '0;
  logic [1:0]  i_store_type = '0, i_wb_sel = '0;
  logic        i_regwen = 1'b0;
  logic        i_dmem_ack = 1'b0;
  logic [31:0] i_dmem_rdata = '0;
  logic        o_dmem_req, o_dmem_we, o_regwen, o_valid, o_stall;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_pc, o_inst, o_alu, o_ld_data;
  logic [3:0]  o_dmem_be;
  logic [1:0]  o_wb_sel, o_exc;

  always #5 i_clk = ~i_clk;

  stage_mem_lsu dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pc(i_pc), .i_inst(i_inst), .i_alu(i_alu),
    .i_rs2(i_rs2), .i_memrw(i_memrw), .i_load_type(i_load_type),
    .i_store_type(i_store_type), .i_wb_sel(i_wb_sel), .i_regwen(i_regwen),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be), .i_dmem_ack(i_dmem_ack),
    .i_dmem_rdata(i_dmem_rdata), .o_pc(o_pc), .o_inst(o_inst), .o_alu(o_alu),
    .o_ld_data(o_ld_data), .o_wb_sel(o_wb_sel), .o_regwen(o_regwen),
    .o_valid(o_valid), .o_stall(o_stall), .o_exc(o_exc)
  );

  int n_chk = 0;
  int n_err = 0;
  int stall_seen = 0;

  // Model: m_w counts cycles the current access has already been outstanding.
  int          m_w = 0, n_w = 0;
  logic        x_stall, x_req, x_we;
  logic [31:0] x_addr, x_wdata;
  logic [3:0]  x_be;
  logic        e_valid, e_regwen, n_valid, n_regwen;
  logic [31:0] e_pc, e_inst, e_alu, e_ld, n_pc, n_inst, n_alu, n_ld;
  logic [1:0]  e_wb, e_exc, n_wb, n_exc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task model_comb();
    logic        ld, st, mem, mis, acc, done, abort;
    int          nb, a_lo, sh;
    logic [31:0] mask, v;
    ld   = (i_wb_sel == WB_MEM) && !i_memrw;
    st   = i_memrw;
    mem  = ld || st;
    if (st) nb = (i_store_type == ST_SB) ? 1 : (i_store_type == ST_SH) ? 2 : 4;
    else    nb = (i_load_type[1:0] == 2'b00) ? 1 : (i_load_type[1:0] == 2'b01) ? 2 : 4;
    a_lo  = int'(i_alu[1:0]);
    mis   = mem && ((a_lo % nb) != 0);
    acc   = mem && !mis && !i_rst;
    done  = acc && i_dmem_ack;
    abort = acc && !i_dmem_ack && (m_w == 16);
    x_stall = acc && !done && !abort;
    x_req   = acc;
    x_we    = acc && st;
    x_addr  = i_alu & 32'hFFFF_FFFC;
    x_be    = 4'(((1 << nb) - 1) << a_lo);
    x_wdata = (nb == 1) ? {4{i_rs2[7:0]}} : (nb == 2) ? {2{i_rs2[15:0]}} : i_rs2;
    mask = (nb == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * nb)) - 1);
    sh   = (nb == 1) ? 8 * a_lo : (nb == 2) ? 16 * (a_lo / 2) : 0;
    v    = (i_dmem_rdata >> sh) & mask;
    if (!i_load_type[2] && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
    if (i_rst) begin
      n_valid = 0; n_regwen = 0; n_pc = 0; n_inst = 0; n_alu = 0; n_ld = 0;
      n_wb = 0; n_exc = 0; n_w = 0;
    end else if (x_stall) begin
      n_valid = 0; n_regwen = 0; n_inst = 0; n_wb = 0; n_exc = 0;
      n_pc = e_pc; n_alu = e_alu; n_ld = e_ld; n_w = m_w + 1;
    end else begin
      n_valid = 1; n_pc = i_pc; n_inst = i_inst; n_alu = i_alu; n_wb = i_wb_sel;
      n_regwen = i_regwen && !mis && !abort;
      n_exc = mis ? 2'b01 : abort ? 2'b10 : 2'b00;
      n_ld = (done && ld) ? v : e_ld;
      n_w = 0;
    end
  endtask

  task commit();
    e_valid = n_valid; e_regwen = n_regwen; e_pc = n_pc; e_inst = n_inst;
    e_alu = n_alu; e_ld = n_ld; e_wb = n_wb; e_exc = n_exc; m_w = n_w;
  endtask

  task compare_all();
    chk("stall", 32'(o_stall), 32'(x_stall));
    if (o_stall === 1'b1) stall_seen++;
    chk("dmem_req", 32'(o_dmem_req), 32'(x_req));
    if (x_req) begin
      chk("dmem_we", 32'(o_dmem_we), 32'(x_we));
      chk("dmem_addr", o_dmem_addr, x_addr);
      chk("dmem_be", 32'(o_dmem_be), 32'(x_be));
      if (x_we) chk("dmem_wdata", o_dmem_wdata, x_wdata);
    end
    chk("valid", 32'(o_valid), 32'(e_valid));
    chk("pc", o_pc, e_pc);
    chk("inst", o_inst, e_inst);
    chk("alu", o_alu, e_alu);
    chk("ld_data", o_ld_data, e_ld);
    chk("wb_sel", 32'(o_wb_sel), 32'(e_wb));
    chk("regwen", 32'(o_regwen), 32'(e_regwen));
    chk("exc", 32'(o_exc), 32'(e_exc));
  endtask

  task step();
    model_comb();
    @(negedge i_clk);
    compare_all();
    @(posedge i_clk);
    commit();
    #1;
  endtask

  task set_op(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
              input logic memrw, input logic [2:0] lt, input logic [1:0] st,
              input logic [1:0] wb, input logic regwen);
    i_pc = pc; i_inst = pc ^ 32'h0000_3A13; i_alu = alu; i_rs2 = rs2;
    i_memrw = memrw; i_load_type = lt; i_store_type = st; i_wb_sel = wb; i_regwen = regwen;
  endtask

  task do_load(input logic [31:0] pc, input logic [2:0] lt, input logic [31:0] a);
    set_op(pc, a, 32'h5555_AAAA, 1'b0, lt, 2'b00, WB_MEM, 1'b1);
  endtask

  task do_store(input logic [31:0] pc, input logic [1:0] st, input logic [31:0] a,
                input logic [31:0] d);
    set_op(pc, a, d, 1'b1, 3'b000, st, WB_ALU, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge i_clk);
    e_valid = 0; e_regwen = 0; e_pc = 0; e_inst = 0; e_alu = 0; e_ld = 0;
    e_wb = 0; e_exc = 0; m_w = 0;
    #1;
    step();
    chk("reset_valid", 32'(o_valid), 32'h0);
    chk("reset_exc", 32'(o_exc), 32'h0);
    i_rst = 1'b0;

    // Pass-through ALU and PC+4 ops, then a bubble.
    set_op(32'h40, 32'h1234_5678, 32'h0, 1'b0, 3'b000, 2'b00, WB_ALU, 1'b1);
    step();
    chk("pass_alu", o_alu, 32'h1234_5678);
    set_op(32'h44, 32'h0000_0048, 32'h0, 1'b0, 3'b000, 2'b00, WB_PC4, 1'b1);
    step();
    set_op(32'h48, 32'h0, 32'h0, 1'b0, 3'b000, 2'b00, WB_ALU, 1'b0);
    i_inst = 32'h0;
    step();
    chk("bubble_valid", 32'(o_valid), 32'h1);
    chk("bubble_regwen", 32'(o_regwen), 32'h0);

    // LW with same-cycle ack.
    do_load(32'h50, LD_LW, 32'h100);
    i_dmem_rdata = 32'hDEAD_BEEF; i_dmem_ack = 1'b1; stall_seen = 0;
    step();
    chk("lw_ld_data", o_ld_data, 32'hDEAD_BEEF);
    chk("lw_valid", 32'(o_valid), 32'h1);
    chk("lw_no_stall", 32'(stall_seen), 32'h0);

    // LB / LBU at 0x103 with ack three cycles after the request.
    do_load(32'h54, LD_LB, 32'h103);
    i_dmem_rdata = 32'h8011_2233; i_dmem_ack = 1'b0; stall_seen = 0;
    repeat (3) step();
    i_dmem_ack = 1'b1;
    step();
    chk("lb_stall_cycles", 32'(stall_seen), 32'd3);
    chk("lb_ld_data", o_ld_data, 32'hFFFF_FF80);
    do_load(32'h58, LD_LBU, 32'h103);
    i_dmem_ack = 1'b0;
    repeat (3) step();
    i_dmem_ack = 1'b1;
    step();
    chk("lbu_ld_data", o_ld_data, 32'h0000_0080);

    // Halfword loads, both halves and both extensions.
    do_load(32'h5C, LD_LH, 32'h102);
    i_dmem_rdata = 32'h8001_7FFF;
    step();
    do_load(32'h60, LD_LHU, 32'h100);
    step();
    do_load(32'h64, LD_LB, 32'h101);
    step();

    // SH at 0x102: lane enables and replicated data.
    do_store(32'h68, ST_SH, 32'h102, 32'h1234_ABCD);
    i_dmem_ack = 1'b0;
    #1;
    chk("sh_be", 32'(o_dmem_be), 32'h0000_000C);
    chk("sh_wdata", o_dmem_wdata, 32'hABCD_ABCD);
    chk("sh_we", 32'(o_dmem_we), 32'h1);
    step();
    i_dmem_ack = 1'b1;
    step();
    chk("sh_regwen", 32'(o_regwen), 32'h0);
    do_store(32'h6C, ST_SB, 32'h101, 32'h0000_00EF);
    step();
    do_store(32'h70, ST_SW, 32'h200, 32'hCAFE_F00D);
    step();
    do_store(32'h74, 2'b11, 32'h204, 32'h0BAD_F00D);
    step();

    // Misaligned accesses: no request, single cycle, exception 01.
    do_load(32'h78, LD_LW, 32'h101);
    i_dmem_ack = 1'b0;
    #1;
    chk("mis_no_req", 32'(o_dmem_req), 32'h0);
    chk("mis_no_stall", 32'(o_stall), 32'h0);
    step();
    chk("mis_exc", 32'(o_exc), 32'h1);
    chk("mis_regwen", 32'(o_regwen), 32'h0);
    do_load(32'h7C, LD_LHU, 32'h101);
    step();
    do_store(32'h80, ST_SH, 32'h103, 32'h1);
    step();
    do_store(32'h84, ST_SW, 32'h102, 32'h2);
    step();
    do_load(32'h88, 3'b011, 32'h102);
    step();
    do_load(32'h8C, 3'b111, 32'h104);
    i_dmem_ack = 1'b1;
    step();

    // SW whose ack never comes: 16 stall cycles, then timeout.
    do_store(32'h90, ST_SW, 32'h300, 32'h1111_2222);
    i_dmem_ack = 1'b0; stall_seen = 0;
    repeat (17) step();
    chk("to_stall_cycles", 32'(stall_seen), 32'd16);
    chk("to_exc", 32'(o_exc), 32'h2);
    chk("to_regwen", 32'(o_regwen), 32'h0);
    set_op(32'h94, 32'h7, 32'h0, 1'b0, 3'b000, 2'b00, WB_ALU, 1'b1);
    i_dmem_ack = 1'b1;
    step();

    // Reset in the middle of a wait, with a late ack around it.
    do_load(32'h98, LD_LW, 32'h400);
    i_dmem_ack = 1'b0; i_dmem_rdata = 32'h1357_9BDF;
    repeat (4) step();
    i_rst = 1'b1; i_dmem_ack = 1'b1;
    step();
    chk("rst_mid_valid", 32'(o_valid), 32'h0);
    chk("rst_mid_exc", 32'(o_exc), 32'h0);
    chk("rst_mid_ld", o_ld_data, 32'h0);
    i_rst = 1'b0;
    set_op(32'h0, 32'h0, 32'h0, 1'b0, 3'b000, 2'b00, WB_ALU, 1'b0);
    i_inst = 32'h0;
    step();
    chk("stray_ack_valid", 32'(o_valid), 32'h1);
    chk("stray_ack_regwen", 32'(o_regwen), 32'h0);
    do_load(32'h9C, LD_LW, 32'h404);
    i_dmem_ack = 1'b0;
    repeat (2) step();
    i_dmem_ack = 1'b1;
    step();
    chk("post_rst_ld", o_ld_data, 32'h1357_9BDF);
    set_op(32'hA0, 32'h0, 32'h0, 1'b0, 3'b000, 2'b00, WB_ALU, 1'b0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/stage_mem_lsu.md
STAGE_MEM_LSU -- requirements
Module: stage_mem_lsu

Interface
REQ-001 SHALL have ports: i_clk in 1, rising-edge clock; i_rst in 1, synchronous active-high reset.
REQ-002 SHALL have EX/MEM-side inputs (32-bit unless stated): i_pc, i_inst, i_alu (effective address / ALU result), i_rs2 (store data), i_memrw 1 (1=store), i_load_type 3, i_store_type 2, i_wb_sel 2, i_regwen 1.
REQ-003 SHALL have data-memory ports: o_dmem_req out 1; o_dmem_we out 1; o_dmem_addr out 32 (word-aligned); o_dmem_wdata out 32; o_dmem_be out 4; i_dmem_ack in 1; i_dmem_rdata in 32.
REQ-004 SHALL have MEM/WB outputs, all registered: o_pc, o_inst, o_alu, o_ld_data (32 each); o_wb_sel 2; o_regwen 1; o_valid 1.
REQ-005 SHALL have o_stall out 1 (hold EX/MEM and upstream) and o_exc out 2 (00 none, 01 misaligned, 10 bus timeout), registered.

Function
REQ-006 Load op = (i_wb_sel == WB_MEM) && !i_memrw; store op = i_memrw; otherwise pass-through.
REQ-007 Load types: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes treated as LW. Store types: 00 SB, 01 SH, 10 SW; 11 treated as SW.
REQ-008 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0; no dmem_req issued; single cycle; o_exc=01; o_regwen forced 0.
REQ-009 o_dmem_addr = {i_alu[31:2],2'b00}; byte enables SB 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111; wdata = rs2 byte/half replicated across all lanes.
REQ-010 FSM states IDLE, WAIT. IDLE + aligned mem op: assert o_dmem_req (o_dmem_we=store) combinationally; ack same cycle -> complete, stay IDLE; else -> WAIT.
REQ-011 WAIT: keep req, we, addr, be, wdata asserted and unchanged; ack -> complete, IDLE; 16 waited cycles without ack -> abort, o_exc=10, o_regwen forced 0, IDLE.
REQ-012 o_stall = aligned mem op && !complete && !abort this cycle; combinational; upstream SHALL hold inputs stable while o_stall=1.
REQ-013 Wait counter 4-bit, cleared on entering WAIT, incremented each WAIT cycle without ack; abort when it reaches 15 with no ack.
REQ-014 i_dmem_ack outside a pending request SHALL be ignored.
REQ-015 Load data: select byte/half by addr[1:0]/addr[1] from i_dmem_rdata; sign-extend LB/LH, zero-extend LBU/LHU; registered into o_ld_data on completion.
REQ-016 Output register update: on complete, abort, misaligned, or non-mem op -> capture pc/inst/alu/wb_sel/regwen (with forcing), o_valid=1; while o_stall=1 -> bubble (o_valid=0, o_regwen=0, o_inst=0, o_wb_sel=0).
REQ-017 Bubble input (i_inst=0, i_regwen=0, i_memrw=0) SHALL produce o_valid=1 with o_regwen=0, no memory access.
REQ-018 Latency: pass-through 1 cycle; memory op N+1 cycles where N = cycles from req to ack (N=0 for same-cycle ack).

Reset
REQ-019 On i_rst at posedge: state IDLE, counter 0, all registered outputs 0 (o_valid=0, o_exc=00); o_dmem_req=0 while i_rst=1.
REQ-020 Reset during WAIT SHALL abandon the pending access without completion; a late ack after reset SHALL be ignored.

Structure
REQ-021 Shared package SHALL hold load/store type encodings, WB_MEM/wb_sel codes, exception codes, state enum, timeout constant (16).
REQ-022 Load extraction/extension SHALL be one combinational sub-module lsu_load_align; the rest is single-module.

Verification
REQ-023 LW addr 0x100, ack same cycle, rdata 0xDEADBEEF -> no stall, next cycle o_ld_data=0xDEADBEEF, o_valid=1.
REQ-024 LB addr 0x103, rdata 0x80xxxxxx, ack after 3 cycles -> o_stall high 3 cycles, req stable, o_ld_data=0xFFFFFF80; LBU -> 0x00000080.
REQ-025 SH addr 0x102, rs2 0x1234ABCD -> be=1100, wdata=0xABCDABCD, we=1, o_regwen=0.
REQ-026 LW addr 0x101 -> no req, o_exc=01, o_regwen=0 next cycle, no stall.
REQ-027 SW with ack never arriving -> 16 stall cycles, then o_exc=10, req drops; i_rst asserted mid-WAIT -> outputs zero next edge, stray ack ignored.
